// File: rtl/spart_pkg.sv
// Loader FSM states and the frame start byte, shared with the host-side download tool model.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHKSUM  = 3'd5,
        ERROR   = 3'd6
    } loader_state_t;

    localparam logic [7:0] LOADER_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/spart_rx_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled, flags expiry at zero.
module spart_rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Loading TIMEOUT_CYCLES-1 makes the TIMEOUT_CYCLES-th byte-less cycle the expiring one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire_c = en && (cnt_q == '0);

endmodule

// File: rtl/spart_program_writer.sv
// Framed serial program download: SPART bytes -> 16-bit instruction memory words,
// holding the CPU in reset while a frame is in flight.
module spart_program_writer
    import spart_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]            HDR_BYTE       = LOADER_HDR_BYTE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_wr,
    output logic                  mem_en,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Largest word count that fits between BASE_ADDR and the top of the address space.
    localparam int unsigned MAX_WORDS = (32'd1 << (ADDR_WIDTH - 1)) - 32'(BASE_ADDR >> 1);

    loader_state_t         state_q, state_d;
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           remain_q, remain_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            chk_q, chk_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [15:0]           wdata_d;
    logic                  wr_d, cpu_rst_n_d, busy_d, done_d, err_d;
    logic [15:0]           len_c;
    logic                  expire_c;

    assign len_c = {cnt_hi_q, rx_data};

    spart_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_valid || (state_q == IDLE)),
        .en      (state_q != IDLE),
        .expire_c(expire_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_hi_q  <= '0;
            remain_q  <= '0;
            hi_q      <= '0;
            chk_q     <= '0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            cpu_rst_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_hi_q  <= cnt_hi_d;
            remain_q  <= remain_d;
            hi_q      <= hi_d;
            chk_q     <= chk_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wr    <= wr_d;
            cpu_rst_n <= cpu_rst_n_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    assign mem_en = mem_wr;

    // Next state and next register values; a received byte always beats timeout expiry.
    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        remain_d    = remain_q;
        hi_d        = hi_q;
        chk_d       = chk_q;
        addr_d      = mem_wr ? (mem_addr + ADDR_WIDTH'(2)) : mem_addr;
        wdata_d     = mem_wdata;
        wr_d        = 1'b0;
        cpu_rst_n_d = cpu_rst_n;
        done_d      = done;
        err_d       = err;

        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == HDR_BYTE)) begin
                    state_d     = LEN_HI;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    cpu_rst_n_d = 1'b0;
                    addr_d      = BASE_ADDR;
                    chk_d       = '0;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    cnt_hi_d = rx_data;
                    chk_d    = chk_q ^ rx_data;
                    state_d  = LEN_LO;
                end else if (expire_c) begin
                    state_d = ERROR;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    chk_d    = chk_q ^ rx_data;
                    remain_d = len_c;
                    if (len_c == '0) begin
                        state_d = CHKSUM;
                    end else if (32'(len_c) > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA_HI;
                    end
                end else if (expire_c) begin
                    state_d = ERROR;
                end
            end
            DATA_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = DATA_LO;
                end else if (expire_c) begin
                    state_d = ERROR;
                end
            end
            DATA_LO: begin
                if (rx_valid) begin
                    wdata_d  = {hi_q, rx_data};
                    wr_d     = 1'b1;
                    chk_d    = chk_q ^ rx_data;
                    remain_d = remain_q - 16'd1;
                    state_d  = (remain_q == 16'd1) ? CHKSUM : DATA_HI;
                end else if (expire_c) begin
                    state_d = ERROR;
                end
            end
            CHKSUM: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    cpu_rst_n_d = 1'b1;
                    state_d     = IDLE;
                end else if (expire_c) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                err_d       = 1'b1;
                cpu_rst_n_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spart_program_writer.sv
// Self-checking bench: frame-position reference model compared every cycle, plus directed literal checks.
module tb_spart_program_writer;

    localparam int unsigned TO     = 40;
    localparam int unsigned MAXW   = 32768;
    localparam logic [7:0]  HDR    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr, mem_en, cpu_rst_n, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    spart_program_writer #(
        .ADDR_WIDTH    (16),
        .BASE_ADDR     (16'h0000),
        .TIMEOUT_CYCLES(TO),
        .HDR_BYTE      (HDR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wr   (mem_wr),
        .mem_en   (mem_en),
        .cpu_rst_n(cpu_rst_n),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks byte position within the frame rather than loader states.
    bit          m_in, m_abort, m_wr, m_cpu, m_busy, m_done, m_err;
    int          m_pos, m_n, m_idle, m_addr;
    logic [7:0]  m_chk, m_hi;
    logic [15:0] m_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in = 0; m_abort = 0; m_wr = 0; m_cpu = 1; m_busy = 0; m_done = 0; m_err = 0;
            m_pos = 0; m_n = 0; m_idle = 0; m_addr = 0; m_chk = 8'h00; m_hi = 8'h00;
            m_wdata = 16'h0000;
        end else begin
            if (m_wr) m_addr = (m_addr + 2) % 65536;
            m_wr = 0;
            if (m_abort) begin
                m_err = 1; m_cpu = 1; m_abort = 0;
            end else if (!m_in) begin
                if (rx_valid && rx_data == HDR) begin
                    m_in = 1; m_pos = 0; m_chk = 8'h00; m_done = 0; m_err = 0;
                    m_cpu = 0; m_addr = 0; m_idle = 0;
                end
            end else if (rx_valid) begin
                m_idle = 0;
                if (m_pos >= 2 && m_pos == 2 + 2 * m_n) begin
                    if (rx_data == m_chk) m_done = 1; else m_err = 1;
                    m_cpu = 1; m_in = 0;
                end else begin
                    m_chk = m_chk ^ rx_data;
                    if (m_pos == 0) begin
                        m_n = int'(rx_data) * 256;
                    end else if (m_pos == 1) begin
                        m_n = m_n + int'(rx_data);
                        if (m_n > int'(MAXW)) begin m_in = 0; m_abort = 1; end
                    end else if (m_pos % 2 == 0) begin
                        m_hi = rx_data;
                    end else begin
                        m_wdata = {m_hi, rx_data};
                        m_wr = 1;
                    end
                    m_pos++;
                end
            end else begin
                m_idle++;
                if (m_idle == int'(TO)) begin m_in = 0; m_abort = 1; end
            end
            m_busy = m_in || m_abort;
        end
    end

    // Log of DUT writes for the directed literal checks.
    logic [31:0] wlog[$];

    always @(negedge clk) begin
        check("mem_wr",    32'(mem_wr),    32'(m_wr));
        check("mem_en",    32'(mem_en),    32'(m_wr));
        check("mem_addr",  32'(mem_addr),  32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
        check("busy",      32'(busy),      32'(m_busy));
        check("done",      32'(done),      32'(m_done));
        check("err",       32'(err),       32'(m_err));
        if (mem_wr === 1'b1) wlog.push_back({mem_addr, mem_wdata});
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i], 0);
    endtask

    task automatic status(input string tag, input logic d, input logic e, input logic b, input logic c);
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".err"}, 32'(err), 32'(e));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(c));
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] b;
        int n, cut;
        logic [7:0] c;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        idle(3);
        status("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset.mem_addr", 32'(mem_addr), 32'h0);
        check("reset.mem_wdata", 32'(mem_wdata), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Good frame: checksum 0x42 is the XOR of 00 02 12 34 AB CD.
        wlog.delete();
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(fr);
        idle(2);
        check("t1.nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("t1.w0", wlog[0], 32'h0000_1234);
            check("t1.w1", wlog[1], 32'h0002_ABCD);
        end
        status("t1", 1'b1, 1'b0, 1'b0, 1'b1);

        // Same frame with a wrong checksum: both words still written.
        wlog.delete();
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_frame(fr);
        idle(2);
        check("t2.nwrites", 32'(wlog.size()), 32'd2);
        status("t2", 1'b0, 1'b1, 1'b0, 1'b1);

        // Stray bytes, then an empty frame.
        wlog.delete();
        fr = '{8'h55, 8'hA4, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        idle(2);
        check("t3.nwrites", 32'(wlog.size()), 32'd0);
        status("t3", 1'b1, 1'b0, 1'b0, 1'b1);

        // Silence mid-frame.
        wlog.delete();
        fr = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_frame(fr);
        idle(TO - 2);
        status("t4.pre", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("t4.nwrites", 32'(wlog.size()), 32'd0);
        status("t4", 1'b0, 1'b1, 1'b0, 1'b1);

        // Byte arriving on the expiry cycle wins; checksum 01^12^34 = 0x27.
        send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
        send(8'h12, TO - 1); send(8'h34, 0); send(8'h27, 0);
        idle(2);
        status("t4b", 1'b1, 1'b0, 1'b0, 1'b1);

        // Oversize count aborts right after the count bytes.
        wlog.delete();
        fr = '{8'hA5, 8'h80, 8'h01};
        send_frame(fr);
        check("t5.busy_in_error", 32'(busy), 32'd1);
        idle(1);
        check("t5.nwrites", 32'(wlog.size()), 32'd0);
        status("t5", 1'b0, 1'b1, 1'b0, 1'b1);

        // Largest legal count is accepted (then left to time out).
        fr = '{8'hA5, 8'h80, 8'h00};
        send_frame(fr);
        idle(1);
        status("t5b", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(TO + 2);

        // Header byte inside a frame is plain data; checksum 01^A5^A5 = 0x01.
        wlog.delete();
        fr = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h01};
        send_frame(fr);
        idle(2);
        if (wlog.size() == 1) check("t5c.w0", wlog[0], 32'h0000_A5A5);
        else check("t5c.nwrites", 32'(wlog.size()), 32'd1);
        status("t5c", 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset between the hi and lo data bytes, then a clean frame (chk 01^BE^EF = 0x50).
        fr = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_frame(fr);
        rst_n = 1'b0;
        #1;
        status("t6.rst", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6.mem_addr", 32'(mem_addr), 32'h0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        wlog.delete();
        fr = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
        send_frame(fr);
        idle(2);
        if (wlog.size() == 1) check("t6.w0", wlog[0], 32'h0000_BEEF);
        else check("t6.nwrites", 32'(wlog.size()), 32'd1);
        status("t6", 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized frames: gaps, strays, bad checksums, oversize counts, timeouts, resets.
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h00;
                send(b, $urandom_range(0, 2));
            end
            n = $urandom_range(0, 5);
            if ($urandom_range(0, 12) == 0) n = 32'h9000;
            fr = '{HDR, 8'(n >> 8), 8'(n)};
            c = 8'(n >> 8) ^ 8'(n);
            if (n <= 5) begin
                for (int k = 0; k < 2 * n; k++) begin
                    b = 8'($urandom);
                    fr.push_back(b);
                    c = c ^ b;
                end
            end
            fr.push_back(($urandom_range(0, 3) == 0) ? (c ^ 8'h01) : c);
            cut = ($urandom_range(0, 10) == 0) ? int'($urandom_range(1, fr.size() - 1)) : -1;
            foreach (fr[i]) begin
                if (i == cut) begin
                    if ($urandom_range(0, 1) == 0) begin
                        idle(TO + 1);
                    end else begin
                        rst_n = 1'b0;
                        idle(1);
                        rst_n = 1'b1;
                    end
                end
                send(fr[i], $urandom_range(0, 3));
            end
            idle($urandom_range(1, 3));
        end

        idle(TO + 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
